// File: rtl/racod_pkg.sv
// Shared types for the RACOD collision-query scheduler:
// FSM states, query fields and default grid geometry.
package racod_pkg;

  localparam int Q_CW       = 16;
  localparam int GRID_W_DEF = 32;
  localparam int GRID_H_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic [Q_CW-1:0] origin_x;
    logic [Q_CW-1:0] origin_y;
    logic [Q_CW-1:0] length;
    logic [Q_CW-1:0] width;
  } query_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting
// at the pointer; the pointer moves past the winner on advance.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_nxt;
  int            w_idx;

  function automatic int wrap(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  // Scan from the far end so the slot nearest the pointer wins.
  always_comb begin
    grant = '0;
    w_nxt = r_ptr;
    w_idx = 0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = wrap(int'(r_ptr) + i);
      if (req[w_idx]) begin
        grant        = '0;
        grant[w_idx] = 1'b1;
        w_nxt        = PW'(wrap(w_idx + 1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance && |req) begin
      r_ptr <= w_nxt;
    end
  end

endmodule

// File: rtl/racod_query_sched.sv
// Collision-query scheduler: arbitrates requesters and walks each
// footprint in LANES-wide batches. Option: RACOD_EARLY_EXIT_EN.
module racod_query_sched
  import racod_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int LANES  = 8,
  parameter int CW     = Q_CW,
  parameter int AW     = 16,
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*4*CW-1:0]   req_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic                    rsp_collision,
  output logic [2*CW-1:0]         rsp_cells,
  output logic                    lk_valid,
  input  logic                    lk_ready,
  output logic [LANES*AW-1:0]     lk_addr,
  output logic [LANES-1:0]        lk_mask,
  input  logic                    lk_rsp_valid,
  input  logic [LANES-1:0]        lk_rsp_hit,
  output logic                    busy
);

`ifdef RACOD_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam int IW  = $clog2(N_REQ);
  localparam int QW  = 4 * CW;
  localparam int XW  = CW + 2;
  localparam int YW  = CW + 1;
  localparam int CLW = 2 * CW;
  localparam int NW  = $clog2(LANES + 1);

  localparam logic [XW-1:0] GW_X = XW'(GRID_W);
  localparam logic [YW-1:0] GH_Y = YW'(GRID_H);
  localparam logic [XW-1:0] LN_X = XW'(LANES);

  state_t         r_state;
  state_t         w_next;
  query_t         r_q;
  logic [IW-1:0]  r_id;
  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;
  logic           r_hit;
  logic [CLW-1:0] r_cells;

  logic [N_REQ-1:0]   w_grant;
  logic [IW-1:0]      w_gidx;
  query_t             w_sel;
  logic               w_zero;
  logic               w_adv;
  logic [XW-1:0]      w_x_end;
  logic [YW-1:0]      w_y_end;
  logic               w_y_oob;
  logic [XW-1:0]      w_lx [LANES];
  logic [LANES-1:0]   w_act;
  logic [LANES-1:0]   w_oob;
  logic [LANES-1:0]   w_mask;
  logic [LANES*AW-1:0] w_addr;
  logic [NW-1:0]      w_cnt;
  logic [XW-1:0]      w_nx;
  logic               w_row_end;
  logic               w_last;
  logic               w_bhit;
  logic               w_done;
  logic               w_eval;

  rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .advance(w_adv),
    .grant  (w_grant)
  );

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) w_gidx = IW'(i);
    end
  end

  assign w_sel  = req_data[int'(w_gidx)*QW +: QW];
  assign w_zero = (w_sel.length == '0) || (w_sel.width == '0);

  // Footprint limits kept one bit wider so edges never wrap.
  assign w_x_end = XW'(r_q.origin_x) + XW'(r_q.length);
  assign w_y_end = YW'(r_q.origin_y) + YW'(r_q.width);
  assign w_y_oob = r_y >= GH_Y;

  always_comb begin
    w_addr = '0;
    w_cnt  = '0;
    for (int i = 0; i < LANES; i++) begin
      w_lx[i]   = r_x + XW'(i);
      w_act[i]  = w_lx[i] < w_x_end;
      w_oob[i]  = w_act[i] & ((w_lx[i] >= GW_X) | w_y_oob);
      w_mask[i] = w_act[i] & ~w_oob[i];
      if (w_mask[i]) begin
        w_addr[i*AW +: AW] =
          AW'(int'(r_y) * GRID_W + int'(w_lx[i]));
      end
      w_cnt = w_cnt + NW'(w_act[i]);
    end
  end

  assign w_nx      = r_x + LN_X;
  assign w_row_end = w_nx >= w_x_end;
  assign w_last    = w_row_end && ((r_y + YW'(1)) >= w_y_end);
  assign w_bhit    = (|(lk_rsp_hit & w_mask)) | (|w_oob);
  assign w_done    = w_last || (EARLY && w_bhit);

  assign w_eval =
    ((r_state == S_ISSUE) && (w_mask == '0)) ||
    ((r_state == S_WAIT) && lk_rsp_valid);

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    lk_valid  = 1'b0;
    w_adv     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (|req_valid) begin
          req_ready = w_grant;
          w_adv     = 1'b1;
          w_next    = w_zero ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_mask == '0) begin
          w_next = w_done ? S_RESP : S_ISSUE;
        end else begin
          lk_valid = 1'b1;
          if (lk_ready) w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lk_rsp_valid) w_next = w_done ? S_RESP : S_ISSUE;
      end
      S_RESP: begin
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_id    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_hit   <= 1'b0;
      r_cells <= '0;
    end else begin
      r_state <= w_next;
      if (w_adv) begin
        r_q     <= w_sel;
        r_id    <= w_gidx;
        r_x     <= XW'(w_sel.origin_x);
        r_y     <= YW'(w_sel.origin_y);
        r_hit   <= 1'b0;
        r_cells <= '0;
      end
      if (w_eval) begin
        r_hit   <= r_hit | w_bhit;
        r_cells <= r_cells + CLW'(w_cnt);
        if (w_row_end) begin
          r_x <= XW'(r_q.origin_x);
          r_y <= r_y + YW'(1);
        end else begin
          r_x <= w_nx;
        end
      end
    end
  end

  assign lk_mask       = (r_state == S_ISSUE) ? w_mask : '0;
  assign lk_addr       = (r_state == S_ISSUE) ? w_addr : '0;
  assign rsp_valid     = r_state == S_RESP;
  assign rsp_id        = r_id;
  assign rsp_collision = r_hit;
  assign rsp_cells     = r_cells;
  assign busy          = r_state != S_IDLE;

endmodule

// File: tb/tb_racod_query_sched.sv
// Directed bench for racod_query_sched with a response scoreboard
// and a latency-programmable lookup responder.
module tb_racod_query_sched;

  localparam int N_REQ = 4;
  localparam int LANES = 8;
  localparam int CW    = 16;
  localparam int AW    = 16;

`ifdef RACOD_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*4*CW-1:0] req_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic                  rsp_collision;
  logic [2*CW-1:0]       rsp_cells;
  logic                  lk_valid;
  logic                  lk_ready;
  logic [LANES*AW-1:0]   lk_addr;
  logic [LANES-1:0]      lk_mask;
  logic                  lk_rsp_valid;
  logic [LANES-1:0]      lk_rsp_hit;
  logic                  busy;

  racod_query_sched dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_collision(rsp_collision),
    .rsp_cells    (rsp_cells),
    .lk_valid     (lk_valid),
    .lk_ready     (lk_ready),
    .lk_addr      (lk_addr),
    .lk_mask      (lk_mask),
    .lk_rsp_valid (lk_rsp_valid),
    .lk_rsp_hit   (lk_rsp_hit),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    bit col;
    int cells;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit   occ[1024];
  int   lat = 1;
  int   pend = 0;
  logic [LANES-1:0] pend_hit;
  int   n_lk = 0;
  int   lk_a0[$];
  int   lk_m[$];
  int   grants[$];
  logic [N_REQ-1:0] prev_rdy = '0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lookup port model: logs each batch, answers after lat cycles.
  initial begin
    lk_rsp_valid = 1'b0;
    lk_rsp_hit   = '0;
    forever begin
      @(negedge clk);
      lk_rsp_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          lk_rsp_valid = 1'b1;
          lk_rsp_hit   = pend_hit;
        end
      end
      #2;
      if (!rst && lk_valid && lk_ready) begin
        n_lk++;
        lk_a0.push_back(int'(lk_addr[AW-1:0]));
        lk_m.push_back(int'(lk_mask));
        for (int i = 0; i < LANES; i++) begin
          pend_hit[i] = lk_mask[i] ?
            occ[int'(lk_addr[i*AW +: AW]) % 1024] : 1'b1;
        end
        pend = lat;
      end
    end
  end

  // Grant logger and response scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        if (req_ready != '0) begin
          chk("rdy_onehot", 64'($onehot(req_ready)), 64'd1);
          chk("rdy_pulse", 64'(prev_rdy), 64'd0);
          for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) grants.push_back(i);
          end
        end
        prev_rdy = req_ready;
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            chk("rsp_unexpected", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            chk("rsp_id", 64'(rsp_id), 64'(e.id));
            chk("rsp_col", 64'(rsp_collision), 64'(e.col));
            chk("rsp_cells", 64'(rsp_cells), 64'(e.cells));
          end
        end
      end
    end
  end

  task automatic send(input int r, input int x, input int y,
                      input int l, input int w);
    int n = 0;
    @(negedge clk);
    req_data[r*4*CW +: 4*CW] = {16'(x), 16'(y), 16'(l), 16'(w)};
    req_valid[r] = 1'b1;
    #1;
    while (!req_ready[r] && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("grant_timeout", 64'd1, 64'd0);
    @(negedge clk);
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk(tag, 64'd1, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench timeout");
  end

  initial begin
    int a2[6];
    int m2[6];
    int n;
    int base;
    logic [LANES*AW-1:0] sa;
    logic [LANES-1:0]    sm;
    logic [2*CW-1:0]     sc;
    logic                scol;
    logic [1:0]          sid;

    a2 = '{0, 8, 16, 32, 40, 48};
    m2 = '{8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF, 8'h0F};
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    lk_ready  = 1'b1;
    foreach (occ[i]) occ[i] = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_lk_valid", 64'(lk_valid), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_cells", 64'(rsp_cells), 64'd0);
    chk("rst_lk_mask", 64'(lk_mask), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single query, one batch of three cells.
    sb.push_back('{id: 0, col: 1'b0, cells: 3});
    base = n_lk;
    send(0, 1, 2, 3, 1);
    #1;
    chk("t1_lk_valid", 64'(lk_valid), 64'd1);
    chk("t1_addr", 64'(lk_addr[3*AW-1:0]),
        64'({16'd67, 16'd66, 16'd65}));
    chk("t1_mask", 64'(lk_mask), 64'h07);
    wait_done("t1_timeout");
    chk("t1_batches", 64'(n_lk - base), 64'd1);

    // Two-row footprint with one occupied cell at addr 36.
    lk_a0.delete();
    lk_m.delete();
    occ[36] = 1'b1;
    sb.push_back('{id: 0, col: 1'b1, cells: EARLY ? 28 : 40});
    send(0, 0, 0, 20, 2);
    wait_done("t2_timeout");
    chk("t2_batches", 64'(lk_a0.size()), EARLY ? 64'd4 : 64'd6);
    for (int i = 0; i < lk_a0.size() && i < 6; i++) begin
      chk("t2_addr0", 64'(lk_a0[i]), 64'(a2[i]));
      chk("t2_mask", 64'(lk_m[i]), 64'(m2[i]));
    end
    occ[36] = 1'b0;

    // Footprint crossing the right and bottom grid edges.
    lk_a0.delete();
    lk_m.delete();
    sb.push_back('{id: 0, col: 1'b1, cells: EARLY ? 4 : 8});
    send(0, 30, 31, 4, 2);
    wait_done("t3_timeout");
    chk("t3_batches", 64'(lk_a0.size()), 64'd1);
    if (lk_a0.size() > 0) begin
      chk("t3_addr0", 64'(lk_a0[0]), 64'd1022);
      chk("t3_mask", 64'(lk_m[0]), 64'h03);
    end

    // Round robin across four continuously valid requesters.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    grants.delete();
    for (int r = 0; r < N_REQ; r++) begin
      req_data[r*4*CW +: 4*CW] =
        {16'(r), 16'd0, 16'(r + 1), 16'd1};
      sb.push_back('{id: r, col: 1'b0, cells: r + 1});
    end
    sb.push_back('{id: 0, col: 1'b0, cells: 1});
    req_valid = '1;
    n = 0;
    while (grants.size() < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    req_valid = '0;
    if (n >= 500) chk("t4_timeout", 64'd1, 64'd0);
    wait_done("t4_done");
    chk("t4_count", 64'(grants.size()), 64'd5);
    for (int i = 0; i < grants.size() && i < 5; i++) begin
      chk("t4_grant", 64'(grants[i]), 64'(i % N_REQ));
    end

    // Backpressure on both the lookup and response sides.
    lk_ready  = 1'b0;
    rsp_ready = 1'b0;
    sb.push_back('{id: 2, col: 1'b0, cells: 3});
    send(2, 1, 2, 3, 1);
    #1;
    sa = lk_addr;
    sm = lk_mask;
    chk("t5_addr", 64'(sa[3*AW-1:0]),
        64'({16'd67, 16'd66, 16'd65}));
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("t5_lk_hold", 64'(lk_valid), 64'd1);
      chk("t5_addr_hold", 64'(lk_addr === sa), 64'd1);
      chk("t5_mask_hold", 64'(lk_mask), 64'(sm));
    end
    lk_ready = 1'b1;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("t5_rsp_timeout", 64'd1, 64'd0);
    sc   = rsp_cells;
    scol = rsp_collision;
    sid  = rsp_id;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("t5_rsp_hold", 64'(rsp_valid), 64'd1);
      chk("t5_fields_hold",
          64'({sid, scol, sc}),
          64'({rsp_id, rsp_collision, rsp_cells}));
    end
    rsp_ready = 1'b1;
    wait_done("t5_done");

    // Reset in WAIT, stale response, then a zero-width query.
    lat = 4;
    sb.push_back('{id: 1, col: 1'b1, cells: 40});
    base = n_lk;
    send(1, 0, 0, 20, 2);
    n = 0;
    while (n_lk == base && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("t6_lk_timeout", 64'd1, 64'd0);
    rst = 1'b1;
    #1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_lk_valid", 64'(lk_valid), 64'd0);
    chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t6_rsp_cells", 64'(rsp_cells), 64'd0);
    chk("t6_lk_addr", 64'(lk_addr == '0), 64'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      chk("t6_stale_idle", 64'(busy), 64'd0);
    end
    lat  = 1;
    base = n_lk;
    sb.push_back('{id: 3, col: 1'b0, cells: 0});
    send(3, 5, 5, 3, 0);
    #1;
    chk("t6_zero_resp", 64'(rsp_valid), 64'd1);
    wait_done("t6_done");
    chk("t6_no_lookup", 64'(n_lk - base), 64'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
